// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal_nic PE/router interface: flit width,
// virtual-channel bit position and the PE register map.
package cardinal_nic_pkg;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 2;
   localparam int VC_BIT = 63;

   typedef enum logic [ADDR_W-1:0] {
      ADDR_IN_BUF   = 2'b00,
      ADDR_IN_STAT  = 2'b01,
      ADDR_OUT_BUF  = 2'b10,
      ADDR_OUT_STAT = 2'b11
   } nic_addr_e;
endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry flit buffer with a full flag; load fills it, clear empties it.
// The data is kept after clear so stale reads return the last flit.
module nic_chan_buf
   import cardinal_nic_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         full
);
   // NOTE: state uses non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/cardinal_nic.sv
// PE <-> router network interface with one flit buffer per direction.
// Optional NIC_REG_DOUT_EN registers the PE read data (d_out).
module cardinal_nic
   import cardinal_nic_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              nicEn,
   input  logic              nicEnWr,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_polarity
);
   logic [DATA_W-1:0] in_buf, out_buf, rd_mux;
   logic              in_full, out_full;
   logic              rd_en, wr_en, in_load, in_clear, out_load;

   assign rd_en = nicEn & ~nicEnWr;
   assign wr_en = nicEn & nicEnWr;

   // Loads are gated by the empty flag, so load and clear never coincide.
   assign in_load  = net_si & ~in_full;
   assign in_clear = rd_en & (addr == ADDR_IN_BUF) & in_full;
   assign out_load = wr_en & (addr == ADDR_OUT_BUF) & ~out_full;

   assign net_ri = ~in_full;
   assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
   assign net_do = out_buf;

   nic_chan_buf #(.W(DATA_W)) u_in_buf (
      .clk   (clk),
      .reset (reset),
      .load  (in_load),
      .clear (in_clear),
      .d     (net_di),
      .q     (in_buf),
      .full  (in_full)
   );

   nic_chan_buf #(.W(DATA_W)) u_out_buf (
      .clk   (clk),
      .reset (reset),
      .load  (out_load),
      .clear (net_so),
      .d     (d_in),
      .q     (out_buf),
      .full  (out_full)
   );

   // NOTE: default assigned first so no path through the case infers a latch.
   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_IN_BUF:   rd_mux = in_buf;
         ADDR_IN_STAT:  rd_mux = {{(DATA_W-1){1'b0}}, in_full};
         ADDR_OUT_STAT: rd_mux = {{(DATA_W-1){1'b0}}, out_full};
         default:       rd_mux = '0;
      endcase
   end

`ifdef NIC_REG_DOUT_EN
   logic [DATA_W-1:0] d_out_q;

   always_ff @(posedge clk) begin
      if (reset)      d_out_q <= '0;
      else if (rd_en) d_out_q <= rd_mux;
   end

   assign d_out = d_out_q;
`else
   assign d_out = rd_en ? rd_mux : '0;
`endif
endmodule

// File: tb/tb_cardinal_nic.sv
// Directed, table-driven bench for cardinal_nic (default combinational d_out).
module tb_cardinal_nic;
   import cardinal_nic_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        addr;
   logic [63:0]       d_in, d_out, net_di, net_do;
   logic              nicEn, nicEnWr, net_si, net_ri, net_so, net_ro, net_polarity;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        en, wr;
      logic [1:0]  a;
      logic [63:0] din;
      logic        si;
      logic [63:0] di;
      logic        ro, pol, rst;
      logic [63:0] e_dout;
      logic        e_ri, e_so;
      logic [63:0] e_do;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   cardinal_nic dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicEnWr      (nicEnWr),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic wr, input logic [1:0] a,
                               input logic [63:0] din, input logic si, input logic [63:0] di,
                               input logic ro, input logic pol, input logic rst,
                               input logic [63:0] e_dout, input logic e_ri, input logic e_so,
                               input logic [63:0] e_do);
      vec_t v;
      v.en = en; v.wr = wr; v.a = a; v.din = din; v.si = si; v.di = di;
      v.ro = ro; v.pol = pol; v.rst = rst;
      v.e_dout = e_dout; v.e_ri = e_ri; v.e_so = e_so; v.e_do = e_do;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      nicEn = v.en; nicEnWr = v.wr; addr = v.a; d_in = v.din;
      net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol; reset = v.rst;
   endtask

   localparam logic [63:0] VC1_0 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] VC1_4 = 64'h8000_0000_0000_0004;
   localparam logic [63:0] VC1_AB = 64'h8000_0000_0000_00AB;

   initial begin
      int so_cnt;
      int first_so;
      vec_t idle;

      idle = mk(0,0,2'd0,0, 0,0, 0,0,0, 0,1,0,0);
      // Vector fields: en wr addr d_in | si di | ro pol rst || d_out ri so do
      // Reset state and status reads
      vecs.push_back(mk(1,0,2'd1,0,       0,0,       0,0,0, 0,1,0,0));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       0,0,0, 0,1,0,0));
      vecs.push_back(mk(1,0,2'd0,0,       0,0,       0,0,0, 0,1,0,0));
      // Output write, VC polarity gating, drain
      vecs.push_back(mk(1,1,2'd2,64'd1234,0,0,       1,1,0, 0,1,0,0));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       1,1,0, 1,1,0,64'd1234));
      vecs.push_back(mk(0,0,2'd0,0,       0,0,       1,0,0, 0,1,1,64'd1234));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       1,0,0, 0,1,0,64'd1234));
      // Write while full is dropped
      vecs.push_back(mk(1,1,2'd2,64'd7,   0,0,       0,0,0, 0,1,0,64'd1234));
      vecs.push_back(mk(1,1,2'd2,VC1_0,   0,0,       0,0,0, 0,1,0,64'd7));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       0,0,0, 1,1,0,64'd7));
      vecs.push_back(mk(0,0,2'd0,0,       0,0,       1,1,0, 0,1,0,64'd7));
      vecs.push_back(mk(0,0,2'd0,0,       0,0,       1,0,0, 0,1,1,64'd7));
      // VC 1 flit only leaves on odd polarity with ready
      vecs.push_back(mk(1,1,2'd2,VC1_4,   0,0,       1,0,0, 0,1,0,64'd7));
      vecs.push_back(mk(0,0,2'd0,0,       0,0,       1,0,0, 0,1,0,VC1_4));
      vecs.push_back(mk(0,0,2'd0,0,       0,0,       0,1,0, 0,1,0,VC1_4));
      vecs.push_back(mk(0,0,2'd0,0,       0,0,       1,1,0, 0,1,1,VC1_4));
      // Send and write in the same cycle: write dropped
      vecs.push_back(mk(1,1,2'd2,64'h9,   0,0,       0,0,0, 0,1,0,VC1_4));
      vecs.push_back(mk(1,1,2'd2,64'hAA,  0,0,       1,0,0, 0,1,1,64'h9));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       0,0,0, 0,1,0,64'h9));
      // Writes to the input buffer address are ignored
      vecs.push_back(mk(1,1,2'd0,64'd5555,0,0,       0,0,0, 0,1,0,64'h9));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       0,0,0, 0,1,0,64'h9));
      vecs.push_back(mk(1,0,2'd0,0,       0,0,       0,0,0, 0,1,0,64'h9));
      // Router input, ignored second send, PE read clears flag, stale read
      vecs.push_back(mk(0,0,2'd0,0,       1,64'd1314,0,0,0, 0,1,0,64'h9));
      vecs.push_back(mk(1,0,2'd1,0,       0,0,       0,0,0, 1,0,0,64'h9));
      vecs.push_back(mk(1,0,2'd1,0,       1,64'd1492,0,0,0, 1,0,0,64'h9));
      vecs.push_back(mk(1,0,2'd0,0,       0,0,       0,0,0, 64'd1314,0,0,64'h9));
      vecs.push_back(mk(1,0,2'd1,0,       0,0,       0,0,0, 0,1,0,64'h9));
      vecs.push_back(mk(1,0,2'd0,0,       0,0,       0,0,0, 64'd1314,1,0,64'h9));
      vecs.push_back(mk(1,0,2'd1,0,       0,0,       0,0,0, 0,1,0,64'h9));
      // Both buffers full, nicEn gating, reset discards both
      vecs.push_back(mk(1,1,2'd2,64'h77,  0,0,       0,0,0, 0,1,0,64'h9));
      vecs.push_back(mk(0,0,2'd0,0,       1,64'h88,  0,0,0, 0,1,0,64'h77));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       0,0,0, 1,0,0,64'h77));
      vecs.push_back(mk(0,0,2'd3,0,       0,0,       0,0,0, 0,0,0,64'h77));
      vecs.push_back(mk(0,0,2'd0,0,       0,0,       0,0,1, 0,0,0,64'h77));
      vecs.push_back(mk(1,0,2'd1,0,       0,0,       0,0,0, 0,1,0,0));
      vecs.push_back(mk(1,0,2'd3,0,       0,0,       1,0,0, 0,1,0,0));
      vecs.push_back(mk(1,0,2'd0,0,       0,0,       0,0,0, 0,1,0,0));

      // Two-cycle reset, then check post-reset outputs
      drive(idle);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ri", {63'd0, net_ri}, 64'd1);
      check("rst_so", {63'd0, net_so}, 64'd0);
      check("rst_do", net_do, 64'd0);
      check("rst_dout", d_out, 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check($sformatf("v%0d_dout", i), d_out, vecs[i].e_dout);
         check($sformatf("v%0d_ri", i), {63'd0, net_ri}, {63'd0, vecs[i].e_ri});
         check($sformatf("v%0d_so", i), {63'd0, net_so}, {63'd0, vecs[i].e_so});
         check($sformatf("v%0d_do", i), net_do, vecs[i].e_do);
         @(posedge clk); #1;
      end

      // VC 1 flit with polarity toggling: sent exactly once, on an odd cycle
      drive(mk(1,1,2'd2,VC1_AB,0,0,0,0,0,0,1,0,0));
      @(posedge clk); #1;
      drive(idle);
      net_ro = 1'b1;
      so_cnt = 0;
      first_so = -1;
      for (int c = 0; c < 6; c++) begin
         net_polarity = c[0];
         @(negedge clk);
         if (net_so) begin
            so_cnt++;
            if (first_so < 0) first_so = c;
            check("seq_do", net_do, VC1_AB);
         end
         @(posedge clk); #1;
      end
      check("seq_so_count", 64'(so_cnt), 64'd1);
      check("seq_first_so", 64'(first_so), 64'd1);
      drive(idle);
      nicEn = 1'b1; addr = 2'd3;
      @(negedge clk);
      check("seq_out_stat", d_out, 64'd0);
      @(posedge clk); #1;
      drive(idle);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
